// File: rtl/mem_stage_pkg.sv
// Shared types and geometry helpers for the memory stage and its data cache.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        DONE
    } state_t;

    localparam int WORDS    = 4;
    localparam int OFFSET_W = 2;

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    // Upper address bits left after index, word offset and byte offset.
    function automatic int tag_w(input int lines);
        return 32 - index_w(lines) - OFFSET_W - 2;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/data storage: one asynchronous read port and one word write port
// that can also install a tag and set the valid bit.
module dcache_array
    import mem_stage_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [index_w(LINES)-1:0]     rd_index,
    output logic [tag_w(LINES)-1:0]       rd_tag,
    output logic                          rd_valid,
    output logic [WORDS-1:0][31:0]        rd_data,
    input  logic                          wr_en,
    input  logic [index_w(LINES)-1:0]     wr_index,
    input  logic [OFFSET_W-1:0]           wr_offset,
    input  logic [31:0]                   wr_data,
    input  logic                          fill_en,
    input  logic [tag_w(LINES)-1:0]       fill_tag
);

    localparam int TAG_W = tag_w(LINES);

    logic [LINES-1:0] valid_reg;
    logic [TAG_W-1:0] tag_mem [LINES];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_reg <= '0;
        end else if (fill_en) begin
            valid_reg[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_mem[wr_index] <= fill_tag;
        end
    end

    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_reg[rd_index];

    // One bank per word position so a single word can be written per cycle.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_bank
            logic [31:0] bank [LINES];

            always_ff @(posedge clock) begin
                if (wr_en && wr_offset == OFFSET_W'(gi)) begin
                    bank[wr_index] <= wr_data;
                end
            end

            assign rd_data[gi] = bank[rd_index];
        end
    endgenerate

endmodule

// File: rtl/mem_stage.sv
// Memory stage with a direct-mapped, write-through, no-write-allocate data cache.
// Optional macro DCACHE_STATS_EN adds hit_count / miss_count outputs.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        icache_stall,
    input  logic [31:0] ac_pc,
    input  logic [4:0]  ac_write_sel,
    input  logic        ac_is_load,
    input  logic        ac_is_store,
    input  logic        ac_is_wb,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ac_data2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        dcache_stall,
    output logic [31:0] cw_pc,
    output logic [4:0]  cw_write_sel,
    output logic        cw_is_wb,
`ifdef DCACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    output logic [31:0] cw_result
);

    localparam int IDX_W = index_w(LINES);
    localparam int TAG_W = tag_w(LINES);

    state_t              state_reg, state_next;
    logic [OFFSET_W-1:0] count_reg, count_next;

    logic [TAG_W-1:0]      addr_tag;
    logic [IDX_W-1:0]      addr_index;
    logic [OFFSET_W-1:0]   addr_offset;
    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_valid;
    logic [WORDS-1:0][31:0] rd_data;
    logic                  hit;
    logic                  wr_en, fill_en, advance;

    assign addr_tag    = ALU_result[31:32-TAG_W];
    assign addr_index  = ALU_result[IDX_W+3:4];
    assign addr_offset = ALU_result[3:2];
    assign hit         = rd_valid && (rd_tag == addr_tag);

    dcache_array #(.LINES(LINES)) u_array (
        .clock    (clock),
        .reset    (reset),
        .rd_index (addr_index),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (addr_index),
        .wr_offset(state_reg == REFILL ? count_reg : addr_offset),
        .wr_data  (state_reg == REFILL ? mem_rdata : ac_data2),
        .fill_en  (fill_en),
        .fill_tag (addr_tag)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        dcache_stall = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        wr_en        = 1'b0;
        fill_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ac_is_load) begin
                    if (!hit) begin
                        dcache_stall = 1'b1;
                        state_next   = REFILL;
                        count_next   = '0;
                    end
                end else if (ac_is_store) begin
                    dcache_stall = 1'b1;
                    state_next   = WRITE;
                end
            end
            REFILL: begin
                dcache_stall = 1'b1;
                mem_req      = 1'b1;
                mem_addr     = {addr_tag, addr_index, count_reg, 2'b00};
                if (mem_ack) begin
                    wr_en      = 1'b1;
                    count_next = count_reg + 2'd1;
                    if (count_reg == 2'd3) begin
                        fill_en    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                dcache_stall = 1'b1;
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = {ALU_result[31:2], 2'b00};
                mem_wdata    = ac_data2;
                if (mem_ack) begin
                    wr_en      = hit;
                    state_next = DONE;
                end
            end
            DONE: begin
                // The retired store must not restart WRITE, so wait until the front end moves.
                if (!icache_stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign advance = !dcache_stall && !icache_stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cw_pc        <= '0;
            cw_write_sel <= '0;
            cw_is_wb     <= 1'b0;
            cw_result    <= '0;
        end else if (advance) begin
            cw_pc        <= ac_pc;
            cw_write_sel <= ac_write_sel;
            cw_is_wb     <= ac_is_wb;
            cw_result    <= ac_is_load ? rd_data[addr_offset] : ALU_result;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_reg == IDLE && ac_is_load) begin
            if (hit && !icache_stall) begin
                hit_count <= hit_count + 32'd1;
            end else if (!hit) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level cache/memory model with random traffic.
module tb_mem_stage;

    localparam int LINES = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        icache_stall = 1'b0;
    logic [31:0] ac_pc = '0;
    logic [4:0]  ac_write_sel = '0;
    logic        ac_is_load = 1'b0, ac_is_store = 1'b0, ac_is_wb = 1'b0;
    logic [31:0] ALU_result = '0, ac_data2 = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        dcache_stall;
    logic [31:0] cw_pc, cw_result;
    logic [4:0]  cw_write_sel;
    logic        cw_is_wb;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    mem_stage #(.LINES(LINES)) dut (
        .clock        (clock),
        .reset        (reset),
        .icache_stall (icache_stall),
        .ac_pc        (ac_pc),
        .ac_write_sel (ac_write_sel),
        .ac_is_load   (ac_is_load),
        .ac_is_store  (ac_is_store),
        .ac_is_wb     (ac_is_wb),
        .ALU_result   (ALU_result),
        .ac_data2     (ac_data2),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .dcache_stall (dcache_stall),
        .cw_pc        (cw_pc),
        .cw_write_sel (cw_write_sel),
        .cw_is_wb     (cw_is_wb),
`ifdef DCACHE_STATS_EN
        .hit_count    (hit_count),
        .miss_count   (miss_count),
`endif
        .cw_result    (cw_result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        req_q[$];
    logic [31:0] mem_model [logic [31:0]];
    logic        mvalid [LINES];
    logic [31:0] mtag [LINES];

    int n_checks = 0, n_fail = 0;
    int ack_delay = 0, wait_cnt = 0, ic_mode = 0, ic_cnt = 0;
    int ack_total = 0, rd_acks = 0, wr_acks = 0;
    int model_misses = 0, model_load_retires = 0;
    logic        cur_is_load = 1'b0;
    logic        hold_prev = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0, last_wr_addr = '0;
    logic [31:0] exp_pc = '0, exp_result = '0, nxt_pc = '0, nxt_result = '0;
    logic [4:0]  exp_sel = '0, nxt_sel = '0;
    logic        exp_wb = 1'b0, nxt_wb = 1'b0;
    logic        lit_valid = 1'b0;
    logic [31:0] lit_val = '0, pc_ctr = 32'h1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // One clock: compare outputs, act as backing memory, then decide whether the instruction retires.
    task automatic step(output logic retired, output logic stalled);
        req_t e;
        @(negedge clock);
        chk("cw_pc", cw_pc, exp_pc);
        chk("cw_write_sel", 32'(cw_write_sel), 32'(exp_sel));
        chk("cw_is_wb", 32'(cw_is_wb), 32'(exp_wb));
        chk("cw_result", cw_result, exp_result);
        if (hold_prev) begin
            chk("req_held", 32'(mem_req), 32'd1);
            chk("addr_stable", mem_addr, prev_addr);
            chk("we_stable", 32'(mem_we), 32'(prev_we));
            chk("wdata_stable", mem_wdata, prev_wdata);
        end
        chk("unexpected_req", 32'(mem_req && req_q.size() == 0), 32'd0);
        case (ic_mode)
            1: icache_stall = ($urandom_range(0, 3) == 0);
            2: icache_stall = (ic_cnt < 14);
            default: icache_stall = 1'b0;
        endcase
        ic_cnt++;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req && req_q.size() != 0) begin
            if (wait_cnt >= ack_delay) begin
                e = req_q.pop_front();
                mem_ack = 1'b1;
                chk("req_we", 32'(mem_we), 32'(e.we));
                chk("req_addr", mem_addr, e.addr);
                if (e.we) begin
                    chk("req_wdata", mem_wdata, e.data);
                    mem_model[e.addr] = e.data;
                    last_wr_addr = mem_addr;
                    wr_acks++;
                end else begin
                    mem_rdata = mem_read(e.addr);
                    rd_acks++;
                end
                ack_total++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        hold_prev  = mem_req && !mem_ack;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
        #1;
        stalled = dcache_stall;
        retired = !dcache_stall && !icache_stall;
        if (retired) begin
            exp_pc = nxt_pc; exp_sel = nxt_sel; exp_wb = nxt_wb; exp_result = nxt_result;
            if (cur_is_load) model_load_retires++;
        end
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store. abort_acks > 0 returns after that many acks.
    task automatic issue(input int kind, input logic [31:0] alu, input logic [31:0] d2,
                         input int abort_acks, output int stall_cycles);
        logic [31:0] a;
        int idx, budget, acks0;
        logic retired, stalled;
        @(posedge clock);
        #1;
        if (lit_valid) begin
            chk("literal_result", cw_result, lit_val);
            lit_valid = 1'b0;
        end
        pc_ctr       = pc_ctr + 32'd4;
        ac_pc        = pc_ctr;
        ac_write_sel = 5'($urandom);
        ac_is_wb     = 1'($urandom);
        ac_is_load   = (kind == 1);
        ac_is_store  = (kind == 2);
        cur_is_load  = (kind == 1);
        ALU_result   = alu;
        ac_data2     = d2;
        a   = {alu[31:2], 2'b00};
        idx = int'(a[7:4]);
        nxt_pc = pc_ctr; nxt_sel = ac_write_sel; nxt_wb = ac_is_wb; nxt_result = alu;
        if (kind == 1) begin
            if (!(mvalid[idx] && mtag[idx] == (a >> 8))) begin
                for (int w = 0; w < 4; w++)
                    req_q.push_back('{we: 1'b0, addr: {a[31:4], 4'b0} + 32'(4 * w), data: 32'd0});
                mvalid[idx] = 1'b1;
                mtag[idx]   = a >> 8;
                model_misses++;
            end
            nxt_result = mem_read(a);
        end else if (kind == 2) begin
            req_q.push_back('{we: 1'b1, addr: a, data: d2});
        end
        stall_cycles = 0;
        budget = 0;
        retired = 1'b0;
        acks0 = ack_total;
        while (!retired && budget < 200) begin
            step(retired, stalled);
            if (stalled) stall_cycles++;
            budget++;
            if (abort_acks > 0 && ack_total - acks0 >= abort_acks) return;
        end
        if (!retired) begin
            n_checks++;
            n_fail++;
            $display("FAIL retire_timeout: pc %h did not retire within %0d cycles", pc_ctr, budget);
        end
        $display("txn pc=%h kind=%0d addr=%h result=%h stalls=%0d", pc_ctr, kind, alu, nxt_result, stall_cycles);
    endtask

    initial begin
        int sc, rd0, wr0;
        logic r, s;
        for (int i = 0; i < LINES; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
        for (int w = 0; w < 4; w++) mem_model[32'h100 + 32'(4 * w)] = 32'hA0 + 32'(w);

        repeat (3) @(negedge clock);
        chk("reset_cw_result", cw_result, 32'd0);
        chk("reset_cw_pc", cw_pc, 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_stall", 32'(dcache_stall), 32'd0);
        reset = 1'b1;

        rd0 = rd_acks;
        issue(1, 32'h100, 32'd0, 0, sc);
        chk("cold_stall_cycles", 32'(sc), 32'd5);
        chk("cold_reads", 32'(rd_acks - rd0), 32'd4);
        lit_val = 32'hA0; lit_valid = 1'b1;

        rd0 = rd_acks;
        issue(1, 32'h104, 32'd0, 0, sc);
        chk("hit_stall_cycles", 32'(sc), 32'd0);
        chk("hit_reads", 32'(rd_acks - rd0), 32'd0);
        lit_val = 32'hA1; lit_valid = 1'b1;

        issue(2, 32'h108, 32'hDEADBEEF, 0, sc);
        chk("store_addr", last_wr_addr, 32'h108);
        rd0 = rd_acks;
        issue(1, 32'h108, 32'd0, 0, sc);
        chk("store_hit_reload_reads", 32'(rd_acks - rd0), 32'd0);
        lit_val = 32'hDEADBEEF; lit_valid = 1'b1;

        rd0 = rd_acks;
        issue(2, 32'h2000, 32'h12345678, 0, sc);
        chk("store_miss_no_refill", 32'(rd_acks - rd0), 32'd0);
        issue(1, 32'h2000, 32'd0, 0, sc);
        chk("load_after_store_miss_reads", 32'(rd_acks - rd0), 32'd4);
        lit_val = 32'h12345678; lit_valid = 1'b1;

        // Reset in the middle of a refill, right after the second ack is taken.
        issue(1, 32'h3040, 32'd0, 2, sc);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_mem_req", 32'(mem_req), 32'd0);
        chk("midreset_cw_result", cw_result, 32'd0);
        chk("midreset_cw_pc", cw_pc, 32'd0);
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
        req_q.delete();
        exp_pc = '0; exp_sel = '0; exp_wb = 1'b0; exp_result = '0;
        hold_prev = 1'b0; mem_ack = 1'b0; wait_cnt = 0; lit_valid = 1'b0;
        model_misses = 0; model_load_retires = 0;
        @(negedge clock);
        reset = 1'b1;
        rd0 = rd_acks;
        issue(1, 32'h3040, 32'd0, 0, sc);
        chk("reload_after_reset_reads", 32'(rd_acks - rd0), 32'd4);

        // Slow ack, front end stalled across DONE.
        issue(1, 32'h100, 32'd0, 0, sc);
        ack_delay = 7; ic_mode = 2; ic_cnt = 0; wr0 = wr_acks;
        issue(2, 32'h10C, 32'hCAFEF00D, 0, sc);
        chk("slow_store_writes", 32'(wr_acks - wr0), 32'd1);
        ack_delay = 0; ic_mode = 0;
        rd0 = rd_acks;
        issue(1, 32'h10C, 32'd0, 0, sc);
        chk("slow_store_hit_reads", 32'(rd_acks - rd0), 32'd0);
        lit_val = 32'hCAFEF00D; lit_valid = 1'b1;

        ic_mode = 1;
        for (int t = 0; t < 150; t++) begin
            logic [31:0] alu;
            alu = (32'($urandom_range(0, 1)) << 20) | (32'($urandom_range(0, 3)) << 8)
                | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
            ack_delay = $urandom_range(0, 3);
            issue($urandom_range(0, 2), alu, $urandom, 0, sc);
        end

        ic_mode = 0; ack_delay = 0;
        issue(0, 32'h55AA55AA, 32'd0, 0, sc);
        @(posedge clock);
        #1;
        ac_is_load = 1'b0; ac_is_store = 1'b0; cur_is_load = 1'b0;
        step(r, s);
        chk("requests_drained", 32'(req_q.size()), 32'd0);
`ifdef DCACHE_STATS_EN
        chk("miss_count", miss_count, 32'(model_misses));
        chk("hit_count", hit_count, 32'(model_load_retires));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
